// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with a start/busy/done handshake.
// Optional leading-zero blanking flags are enabled by defining BIN_TO_BCD_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   d,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state, state_next;
  logic [WIDTH-1:0]    shift_reg;
  logic [4*DIGITS-1:0] acc, acc_adj, acc_shift;
  logic [CW-1:0]       cnt;
  logic                last_iter;

  assign last_iter = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONV);
  end

  // Add-3 correction happens before the shift so no digit can reach 10 after doubling.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_shift = {acc_adj[4*DIGITS-2:0], shift_reg[WIDTH-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      acc       <= '0;
      cnt       <= '0;
      d         <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin;
            acc       <= '0;
            cnt       <= CW'(WIDTH);
          end
        end
        CONV: begin
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          acc       <= acc_shift;
          cnt       <= cnt - CW'(1);
          if (last_iter) begin
            d    <= acc_shift;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BIN_TO_BCD_BLANK_EN
  // Scan from the most significant digit down; blanking stops at the first nonzero digit.
  always_comb begin
    logic zero_above;
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (d[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results, a monitor
// pops and compares them on every done pulse.
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] d;
  logic [DIGITS-1:0]   blank;

  typedef struct {
    logic [4*DIGITS-1:0] d;
    logic [DIGITS-1:0]   blankOn;
  } exp_t;

  exp_t sb[$];
  int   numChecks = 0;
  int   numFails  = 0;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .blank (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DIGITS-1:0] blankFor(input logic [DIGITS-1:0] blankOn);
`ifdef BIN_TO_BCD_BLANK_EN
    return blankOn;
`else
    return '0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] value, input logic [4*DIGITS-1:0] expD,
                               input logic [DIGITS-1:0] expBlankOn, input bit expectResult);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    bin   = value;
    if (expectResult) begin
      e.d = expD;
      e.blankOn = expBlankOn;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = ~value;
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int k = 1; k <= WIDTH + 8; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) $display("[TB] FAIL done_timeout: got no done, expected one within %0d clocks", WIDTH + 8);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      checkOutput("done_busy_exclusive", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("d_value", {12'd0, d}, {12'd0, e.d});
        checkOutput("blank", {27'd0, blank}, {27'd0, blankFor(e.blankOn)});
      end
    end
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_d", {12'd0, d}, 32'd0);
    checkOutput("reset_blank", {27'd0, blank}, {27'd0, blankFor(5'b11110)});
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(16'd0, 20'h00000, 5'b11110, 1'b1);
    checkOutput("busy_after_capture", {31'd0, busy}, 32'd1);
    waitDone(lat);
    checkOutput("latency_zero", lat, WIDTH);

    applyStimulus(16'd65535, 20'h65535, 5'b00000, 1'b1);
    waitDone(lat);
    checkOutput("latency_max", lat, WIDTH);
    checkOutput("busy_in_done_cycle", {31'd0, busy}, 32'd0);

    applyStimulus(16'd1234, 20'h01234, 5'b10000, 1'b1);
    waitDone(lat);

    applyStimulus(16'd10000, 20'h10000, 5'b00000, 1'b1);
    waitDone(lat);

    // A start pulse in the middle of a conversion must be dropped, not queued.
    applyStimulus(16'd500, 20'h00500, 5'b11000, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    bin   = 16'd9;
    checkOutput("busy_mid_conv", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(lat);
    checkOutput("latency_ignored_start", lat, WIDTH - 5);
    repeat (WIDTH + 4) @(posedge clk);
    checkOutput("idle_after_ignored", {31'd0, busy}, 32'd0);

    // Start held high: the second capture happens in the idle cycle showing done.
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd42;
    begin
      exp_t e;
      e.d = 20'h00042; e.blankOn = 5'b11100;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bin = 16'd99;
    waitDone(lat);
    checkOutput("latency_b2b_first", lat, WIDTH);
    begin
      exp_t e;
      e.d = 20'h00099; e.blankOn = 5'b11100;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy_b2b_second", {31'd0, busy}, 32'd1);
    waitDone(lat);
    checkOutput("latency_b2b_second", lat, WIDTH);

    // Reset in the middle of a conversion: no result, d cleared.
    applyStimulus(16'd777, 20'h00777, 5'b11000, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_d", {12'd0, d}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (WIDTH + 4) @(posedge clk);

    applyStimulus(16'd7, 20'h00007, 5'b11110, 1'b1);
    waitDone(lat);
    checkOutput("latency_after_abort", lat, WIDTH);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
